// File: rtl/ram_ctrl.sv
// ram_ctrl -- CPU-side controller for a 4-bit nibble RAM with status characters
// and optional output ports.
//
// Commands are taken only in IDLE. SRC and DCL update the address registers.
// WRM/WRS and RDM/RDS capture the full RAM address at accept, so a later SRC
// or DCL cannot disturb an access that is already running.
// A write asserts ramWe for one cycle. A read asserts ramRe for one cycle.
// The RAM returns registered data one cycle later, and that data is passed
// straight through to rspData while rspValid is high.
//
// Build option: define RAM_CTRL_OUTPORT_EN so that WMP writes the nibble port
// of the chip selected by srcReg[7:6]. Without it, WMP is a no-op and portOut
// is tied to zero.
module ram_ctrl (
   input  logic        clk,
   input  logic        rstN,
   input  logic        cmdValid,
   output logic        cmdReady,
   input  logic [2:0]  cmdOp,
   input  logic [1:0]  cmdIdx,
   input  logic [7:0]  cmdData,
   output logic        rspValid,
   output logic [3:0]  rspData,
   output logic [11:0] ramAddr,
   output logic        ramWe,
   output logic        ramRe,
   output logic [3:0]  ramDataIn,
   input  logic [3:0]  ramDataOut,
   output logic [15:0] portOut
);

   localparam logic [2:0] OP_SRC = 3'd0;
   localparam logic [2:0] OP_DCL = 3'd1;
   localparam logic [2:0] OP_WRM = 3'd2;
   localparam logic [2:0] OP_RDM = 3'd3;
   localparam logic [2:0] OP_WRS = 3'd4;
   localparam logic [2:0] OP_RDS = 3'd5;
   localparam logic [2:0] OP_WMP = 3'd6;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state;
   logic [7:0]  srcReg;    // {chip, reg, char}
   logic [2:0]  bank;
   logic        pendRead;  // the access in flight is a read, so go on to RESP
   logic        accept;
   logic [11:0] accAddr;

   assign cmdReady = (state == IDLE);
   assign accept   = cmdValid & cmdReady;

   // Status characters sit in the S=1 half of each register; main characters are in the S=0 half.
   always_comb begin
      accAddr = {bank, srcReg[7:4], 1'b0, srcReg[3:0]};
      if (cmdOp == OP_WRS || cmdOp == OP_RDS)
         accAddr = {bank, srcReg[7:4], 1'b1, 2'b00, cmdIdx};
   end

   // The read nibble is visible only during the response cycle and reads as zero otherwise.
   assign rspData = rspValid ? ramDataOut : 4'h0;

   // Command FSM: IDLE -> ACCESS (-> RESP for reads) -> IDLE, with all strobes registered.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state     <= IDLE;
         srcReg    <= 8'h00;
         bank      <= 3'd0;
         pendRead  <= 1'b0;
         ramAddr   <= 12'h000;
         ramWe     <= 1'b0;
         ramRe     <= 1'b0;
         ramDataIn <= 4'h0;
         rspValid  <= 1'b0;
      end else begin
         ramWe    <= 1'b0;
         ramRe    <= 1'b0;
         rspValid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  case (cmdOp)
                     OP_SRC: srcReg <= cmdData;
                     OP_DCL: bank   <= cmdData[2:0];
                     OP_WRM, OP_WRS: begin
                        ramAddr   <= accAddr;
                        ramDataIn <= cmdData[3:0];
                        ramWe     <= 1'b1;
                        pendRead  <= 1'b0;
                        state     <= ACCESS;
                     end
                     OP_RDM, OP_RDS: begin
                        ramAddr  <= accAddr;
                        ramRe    <= 1'b1;
                        pendRead <= 1'b1;
                        state    <= ACCESS;
                     end
                     default: ;  // WMP and NOP finish in the accept cycle
                  endcase
               end
            end
            ACCESS: begin
               if (pendRead) begin
                  rspValid <= 1'b1;
                  state    <= RESP;
               end else begin
                  state <= IDLE;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RAM_CTRL_OUTPORT_EN
   // WMP loads the nibble port of the chip that SRC currently selects.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)
         portOut <= 16'h0000;
      else if (accept && cmdOp == OP_WMP)
         portOut[{srcReg[7:6], 2'b00} +: 4] <= cmdData[3:0];
   end
`else
   assign portOut = 16'h0000;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl -- directed, table-driven bench for ram_ctrl. A behavioral nibble
// RAM (11-bit decode, registered read) is attached to the DUT. Each table row
// drives one cycle of command inputs and gives the outputs expected in the
// cycle that follows. Hand-written sequences cover reset and abort behavior.
// The expected portOut values depend on whether RAM_CTRL_OUTPORT_EN is defined.
module tb_ram_ctrl;

   localparam logic [2:0] SRC = 3'd0, DCL = 3'd1, WRM = 3'd2, RDM = 3'd3;
   localparam logic [2:0] WRS = 3'd4, RDS = 3'd5, WMP = 3'd6, NOP = 3'd7;
`ifdef RAM_CTRL_OUTPORT_EN
   localparam logic [15:0] P1 = 16'h0090, P2 = 16'hA090;
`else
   localparam logic [15:0] P1 = 16'h0000, P2 = 16'h0000;
`endif

   typedef struct packed {
      logic       v;
      logic [2:0] op;
      logic [1:0] idx;
      logic [7:0] data;
   } vin_t;

   typedef struct packed {
      logic        rdy, we, re;
      logic [11:0] addr;
      logic [3:0]  din;
      logic        rv;
      logic [3:0]  rd;
      logic [15:0] port;
   } vout_t;

   typedef struct packed {
      vin_t  i;
      vout_t o;
   } vec_t;

   logic        clk = 1'b0, rstN = 1'b0;
   logic        cmdValid = 1'b0, cmdReady;
   logic [2:0]  cmdOp = 3'd0;
   logic [1:0]  cmdIdx = 2'd0;
   logic [7:0]  cmdData = 8'h00;
   logic        rspValid, ramWe, ramRe;
   logic [3:0]  rspData, ramDataIn, ramDataOut;
   logic [11:0] ramAddr;
   logic [15:0] portOut;

   int errors = 0, checks = 0;
   vec_t vecs[$];
   logic [3:0] mem [2048];
   logic [3:0] rdq = 4'h0;
   vout_t rstOut;

   ram_ctrl dut (
      .clk(clk), .rstN(rstN), .cmdValid(cmdValid), .cmdReady(cmdReady),
      .cmdOp(cmdOp), .cmdIdx(cmdIdx), .cmdData(cmdData),
      .rspValid(rspValid), .rspData(rspData), .ramAddr(ramAddr),
      .ramWe(ramWe), .ramRe(ramRe), .ramDataIn(ramDataIn),
      .ramDataOut(ramDataOut), .portOut(portOut)
   );

   always #5 clk = ~clk;

   // Behavioral RAM: only addr[10:0] is decoded, and read data is registered.
   initial for (int a = 0; a < 2048; a++) mem[a] = 4'h0;
   always @(posedge clk) begin
      if (ramWe) mem[ramAddr[10:0]] <= ramDataIn;
      if (ramRe) rdq <= mem[ramAddr[10:0]];
   end
   assign ramDataOut = rdq;

   function automatic vout_t curOut();
      curOut = '{rdy: cmdReady, we: ramWe, re: ramRe, addr: ramAddr, din: ramDataIn,
                 rv: rspValid, rd: rspData, port: portOut};
   endfunction

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [2:0] op, input logic [1:0] idx,
                      input logic [7:0] data, input logic rdy, input logic we, input logic re,
                      input logic [11:0] addr, input logic [3:0] din, input logic rv,
                      input logic [3:0] rd, input logic [15:0] port);
      vec_t t;
      t.i = '{v: v, op: op, idx: idx, data: data};
      t.o = '{rdy: rdy, we: we, re: re, addr: addr, din: din, rv: rv, rd: rd, port: port};
      vecs.push_back(t);
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] idx,
                        input logic [7:0] data);
      cmdValid = v; cmdOp = op; cmdIdx = idx; cmdData = data;
   endtask

   initial begin
      logic sawRsp;
      rstOut = '{rdy: 1'b1, default: '0};

      //    v  op   idx  data   rdy we re addr    din  rv rd    port
      add(1, WRM, 0, 8'h01,  0, 1, 0, 12'h000, 4'h1, 0, 4'h0, 16'h0); // src/bank zero after reset
      add(0, NOP, 0, 8'h00,  1, 0, 0, 12'h000, 4'h1, 0, 4'h0, 16'h0);
      add(1, DCL, 0, 8'h02,  1, 0, 0, 12'h000, 4'h1, 0, 4'h0, 16'h0);
      add(1, SRC, 0, 8'h5A,  1, 0, 0, 12'h000, 4'h1, 0, 4'h0, 16'h0);
      add(1, WRM, 0, 8'h07,  0, 1, 0, 12'h4AA, 4'h7, 0, 4'h0, 16'h0);
      add(0, NOP, 0, 8'h00,  1, 0, 0, 12'h4AA, 4'h7, 0, 4'h0, 16'h0);
      add(1, RDM, 0, 8'h00,  0, 0, 1, 12'h4AA, 4'h7, 0, 4'h0, 16'h0);
      add(0, NOP, 0, 8'h00,  0, 0, 0, 12'h4AA, 4'h7, 1, 4'h7, 16'h0);
      add(0, NOP, 0, 8'h00,  1, 0, 0, 12'h4AA, 4'h7, 0, 4'h0, 16'h0);
      add(1, WRS, 3, 8'h0C,  0, 1, 0, 12'h4B3, 4'hC, 0, 4'h0, 16'h0);
      add(0, NOP, 0, 8'h00,  1, 0, 0, 12'h4B3, 4'hC, 0, 4'h0, 16'h0);
      add(1, RDS, 3, 8'h00,  0, 0, 1, 12'h4B3, 4'hC, 0, 4'h0, 16'h0);
      add(0, NOP, 0, 8'h00,  0, 0, 0, 12'h4B3, 4'hC, 1, 4'hC, 16'h0);
      add(0, NOP, 0, 8'h00,  1, 0, 0, 12'h4B3, 4'hC, 0, 4'h0, 16'h0);
      add(1, WRM, 0, 8'h03,  0, 1, 0, 12'h4AA, 4'h3, 0, 4'h0, 16'h0);
      add(1, SRC, 0, 8'hFF,  1, 0, 0, 12'h4AA, 4'h3, 0, 4'h0, 16'h0); // offered while busy: dropped
      add(1, RDM, 0, 8'h00,  0, 0, 1, 12'h4AA, 4'h3, 0, 4'h0, 16'h0);
      add(0, NOP, 0, 8'h00,  0, 0, 0, 12'h4AA, 4'h3, 1, 4'h3, 16'h0);
      add(0, NOP, 0, 8'h00,  1, 0, 0, 12'h4AA, 4'h3, 0, 4'h0, 16'h0);
      add(1, DCL, 0, 8'h06,  1, 0, 0, 12'h4AA, 4'h3, 0, 4'h0, 16'h0);
      add(1, WRM, 0, 8'h05,  0, 1, 0, 12'hCAA, 4'h5, 0, 4'h0, 16'h0); // bank 6 aliases bank 2
      add(0, NOP, 0, 8'h00,  1, 0, 0, 12'hCAA, 4'h5, 0, 4'h0, 16'h0);
      add(1, DCL, 0, 8'h02,  1, 0, 0, 12'hCAA, 4'h5, 0, 4'h0, 16'h0);
      add(1, RDM, 0, 8'h00,  0, 0, 1, 12'h4AA, 4'h5, 0, 4'h0, 16'h0);
      add(0, NOP, 0, 8'h00,  0, 0, 0, 12'h4AA, 4'h5, 1, 4'h5, 16'h0);
      add(0, NOP, 0, 8'h00,  1, 0, 0, 12'h4AA, 4'h5, 0, 4'h0, 16'h0);
      add(1, SRC, 0, 8'h40,  1, 0, 0, 12'h4AA, 4'h5, 0, 4'h0, 16'h0);
      add(1, WMP, 0, 8'h09,  1, 0, 0, 12'h4AA, 4'h5, 0, 4'h0, P1);
      add(1, NOP, 0, 8'h0F,  1, 0, 0, 12'h4AA, 4'h5, 0, 4'h0, P1);
      add(1, SRC, 0, 8'hC0,  1, 0, 0, 12'h4AA, 4'h5, 0, 4'h0, P1);
      add(1, WMP, 0, 8'h0A,  1, 0, 0, 12'h4AA, 4'h5, 0, 4'h0, P2);

      // Power-on reset
      repeat (2) @(posedge clk);
      #1 chk("reset_outputs", curOut(), rstOut);
      rstN = 1'b1;
      @(posedge clk); #1 chk("ready_after_reset", {39'd0, cmdReady}, 40'd1);

      foreach (vecs[k]) begin
         drive(vecs[k].i.v, vecs[k].i.op, vecs[k].i.idx, vecs[k].i.data);
         @(posedge clk); #1;
         chk($sformatf("vec%0d", k), curOut(), vecs[k].o);
      end
      drive(0, NOP, 0, 8'h00);

      // Reset pulse mid-idle, while addr, data, and ports are non-zero
      #2 rstN = 1'b0;
      #1 chk("mididle_reset_outputs", curOut(), rstOut);
      @(posedge clk); #1 rstN = 1'b1;
      @(posedge clk); #1 chk("mididle_ready_after", {39'd0, cmdReady}, 40'd1);

      // Read aborted by reset during the access cycle
      drive(1, RDM, 0, 8'h00);
      @(posedge clk); #1 chk("abort_re_high", {27'd0, ramRe, ramAddr}, {27'd0, 1'b1, 12'h000});
      drive(0, NOP, 0, 8'h00);
      #2 rstN = 1'b0;
      #1 chk("abort_strobes_drop", {37'd0, ramRe, ramWe, rspValid}, 40'd0);
      @(posedge clk); #1 rstN = 1'b1;
      sawRsp = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1 if (rspValid) sawRsp = 1'b1;
      end
      chk("abort_no_rsp", {39'd0, sawRsp}, 40'd0);

      // cmdValid is held high through a read: nothing is accepted while busy
      drive(1, RDM, 0, 8'h00);
      @(posedge clk); #1 chk("hold_t1", {37'd0, cmdReady, ramRe, ramWe}, {37'd0, 3'b010});
      @(posedge clk); #1 chk("hold_t2", {32'd0, cmdReady, ramRe, ramWe, rspValid, rspData},
                              {32'd0, 4'b0001, 4'h1});
      drive(0, NOP, 0, 8'h00);
      @(posedge clk); #1 chk("hold_t3", {36'd0, cmdReady, ramRe, ramWe, rspValid},
                              {36'd0, 4'b1000});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
